// File: rtl/fetch_pipe_ctrl.sv
// Front-end pipeline registers: PC, IF/ID and the control half of ID/EX, driven by
// hazard-detector stall/bubble requests and EX-stage branch flushes, plus event counters.
module fetch_pipe_ctrl #(
  parameter int              XLEN     = 64,
  parameter int              CTRL_W   = 12,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_load,
  input  logic              if_id_load,
  input  logic              mux5_selector,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [31:0]       instr_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_valid,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [31:0]      NOP     = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic bubble;
  logic stall_event;

  // A bubble enters ID/EX on a flush, a hazard request, or when IF/ID is empty.
  assign bubble      = branch_taken || mux5_selector || !if_id_valid;
  assign stall_event = !pc_load && !branch_taken;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_id_pc    <= '0;
      if_id_instr <= NOP;
      if_id_valid <= 1'b0;
      id_ex_ctrl  <= '0;
      id_ex_valid <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (branch_taken) begin
        pc <= branch_target;
      end else if (pc_load) begin
        pc <= pc + XLEN'(4);
      end

      // A taken branch squashes both younger instructions: IF/ID and the one in fetch.
      if (branch_taken) begin
        if_id_pc    <= '0;
        if_id_instr <= NOP;
        if_id_valid <= 1'b0;
      end else if (if_id_load) begin
        if_id_pc    <= pc;
        if_id_instr <= instr_in;
        if_id_valid <= 1'b1;
      end

      if (bubble) begin
        id_ex_ctrl  <= '0;
        id_ex_valid <= 1'b0;
      end else begin
        id_ex_ctrl  <= ctrl_in;
        id_ex_valid <= 1'b1;
      end

      if (stall_event && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (branch_taken && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/fetch_pipe_ctrl.md
# fetch_pipe_ctrl

Front-end pipeline register block for the five-stage RISC-V core. It owns the PC register, the IF/ID pipeline register and the control half of the ID/EX pipeline register. It executes the stall and bubble requests issued by the ID-stage hazard detector and the flush requested by branch resolution in EX. It also keeps saturating stall/flush event counters for the performance report.

## Interface

Parameters:
- XLEN, 64, width of PC and branch target
- CTRL_W, 12, width of the ID/EX control bundle from the main controller
- RESET_PC, 0, PC value after reset
- CNT_W, 32, width of each event counter

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on a rising edge where it is high
- pc_load  input  1  hazard detector: 1 = advance PC, 0 = hold PC
- if_id_load  input  1  hazard detector: 1 = capture fetch into IF/ID, 0 = hold IF/ID
- mux5_selector  input  1  hazard detector: 1 = inject bubble (zero control) into ID/EX
- branch_taken  input  1  EX stage: branch/jump resolved taken this cycle
- branch_target  input  XLEN  EX stage: redirect address, valid when branch_taken=1
- instr_in  input  32  instruction memory read data for address pc (combinational fetch)
- ctrl_in  input  CTRL_W  main controller output for the instruction in IF/ID
- pc  output  XLEN  current fetch address
- if_id_pc  output  XLEN  PC of instruction held in IF/ID
- if_id_instr  output  32  instruction held in IF/ID
- if_id_valid  output  1  IF/ID holds a real instruction
- id_ex_ctrl  output  CTRL_W  registered ID/EX control bundle
- id_ex_valid  output  1  ID/EX holds a real instruction
- stall_count  output  CNT_W  cycles in which the front end stalled
- flush_count  output  CNT_W  number of taken-branch flushes

## Operation

- NOP encoding: 32'h0000_0013 (addi x0,x0,0).
- PC update, priority order: reset -> RESET_PC; branch_taken -> branch_target; pc_load=1 -> pc+4, wrapping modulo 2^XLEN; otherwise hold.
- IF/ID update, priority order:
  - reset or branch_taken -> instr=NOP, pc=0, valid=0.
  - if_id_load=1 -> instr=instr_in, pc=pc, valid=1.
  - Otherwise hold all three fields.
- ID/EX control update: reset, branch_taken, mux5_selector=1, or if_id_valid=0 -> id_ex_ctrl=0, id_ex_valid=0. Otherwise id_ex_ctrl=ctrl_in, id_ex_valid=1. Updated every cycle; there is no hold.
- branch_taken overrides pc_load, if_id_load and mux5_selector in the same cycle. Squashes the two younger instructions: the one in IF/ID and the one being fetched.
- stall_count: +1 on each edge with pc_load=0, branch_taken=0, reset=0.
- flush_count: +1 on each edge with branch_taken=1, reset=0.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- Inconsistent hazard inputs (pc_load=1 with if_id_load=0): PC advances and IF/ID holds, as commanded. Not checked.
- Reset values: pc=RESET_PC; if_id_instr=NOP; if_id_pc=0; if_id_valid=0; id_ex_ctrl=0; id_ex_valid=0; stall_count=0; flush_count=0.

## Timing

- All outputs are registered. An input sampled at edge N is reflected on the outputs after edge N. No combinational input-to-output path.
- Fetch-to-IF/ID latency: 1 cycle. IF/ID-to-ID/EX control latency: 1 cycle.
- A stall of k cycles (pc_load=if_id_load=0, mux5_selector=1) holds pc and IF/ID for k edges and produces k bubbles in ID/EX.
- Flush: on the edge where branch_taken=1, pc becomes the target, IF/ID becomes invalid and ID/EX becomes a bubble. The target instruction appears in IF/ID one edge later, provided if_id_load=1.
- First valid ID/EX entry after reset deassert: 2 edges (IF/ID fills, then ID/EX).
- Reset asserted mid-stall or mid-flush: takes effect at the next edge and overrides all other inputs. The counters clear too.

## Test plan

- Reset then free run: hold reset 2 cycles with RESET_PC=0, pc_load=if_id_load=1, instr_in=32'h00500093. Required: pc=0,4,8 on successive edges; if_id_valid=1 after the first edge with if_id_pc=0; id_ex_valid=1 after the second edge with id_ex_ctrl=ctrl_in.
- Load-use stall: with pc=0x10, drive pc_load=if_id_load=0 and mux5_selector=1 for 2 cycles. Required: pc stays 0x10; IF/ID holds; id_ex_ctrl=0 for 2 cycles; stall_count=2. Resuming gives pc=0x14.
- Taken branch: at pc=0x20, drive branch_taken=1, branch_target=0x100. Required: next pc=0x100, if_id_instr=NOP, if_id_valid=0, id_ex_valid=0, flush_count=1. One edge later if_id_pc=0x100.
- Branch during stall: drive branch_taken=1 together with pc_load=0 and mux5_selector=1, target 0x40. Required: pc=0x40, flush_count +1, stall_count unchanged.
- Counter saturation and PC wrap: run with CNT_W=4 and stall 20 cycles -> stall_count=15. Set pc=2^XLEN-4 via branch and advance once -> pc=0.
- Reset mid-stall: assert reset in the 2nd stall cycle. Required: all outputs at their reset values after that edge, including stall_count=0.
